// File: rtl/time_pkg.sv
// Shared constants and types for the h:m:s timekeeping counter.
package time_pkg;
   localparam int SEC_MOD_D = 60;
   localparam int MIN_MOD_D = 60;
   localparam int HR_MOD_D  = 24;
   localparam int DAY_MOD_D = 7;

   typedef logic [7:0] field_t;
endpackage

// File: rtl/ct_mod_n.sv
// Modulo-N up counter with synchronous reset and a terminal-count carry flag.
module ct_mod_n #(
   parameter int N     = 60,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] ct_out,
   output logic             z
);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

   logic [WIDTH-1:0] ct_q, ct_d;

   always_comb begin
      ct_d = ct_q;
      if (en) begin
         ct_d = (ct_q == LAST) ? '0 : ct_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ct_q <= '0;
      end else begin
         ct_q <= ct_d;
      end
   end

   assign ct_out = ct_q;
   assign z      = en && (ct_q == LAST);
endmodule

// File: rtl/time_counter_hms.sv
// Cascaded seconds/minutes/hours counter with manual set pulses.
// Optional day-of-week output `days` when TIME_DAY_COUNT_EN is defined.
module time_counter_hms
   import time_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SEC_MOD = SEC_MOD_D,
   parameter int MIN_MOD = MIN_MOD_D,
   parameter int HR_MOD  = HR_MOD_D
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             run_en,
   input  logic             set_min,
   input  logic             set_hr,
   output logic [WIDTH-1:0] secs,
   output logic [WIDTH-1:0] mins,
   output logic [WIDTH-1:0] hrs,
`ifdef TIME_DAY_COUNT_EN
   output logic [2:0]       days,
`endif
   output logic             day_wrap
);
   logic set_any, run_tick;
   logic sec_rst, min_en, hr_en;
   logic sec_z, min_z, hr_z;
   logic wrap_d, day_wrap_q;

   // Set pulses take priority over tick and suppress any cascaded carry.
   assign set_any  = set_min | set_hr;
   assign run_tick = tick & run_en & ~set_any;
   assign sec_rst  = reset | set_any;
   assign min_en   = set_min | sec_z;
   assign hr_en    = set_hr | (min_z & ~set_any);
   assign wrap_d   = hr_z & ~set_any;

   ct_mod_n #(.N(SEC_MOD), .WIDTH(WIDTH)) u_sec (
      .clk    (clk),
      .reset  (sec_rst),
      .en     (run_tick),
      .ct_out (secs),
      .z      (sec_z)
   );

   ct_mod_n #(.N(MIN_MOD), .WIDTH(WIDTH)) u_min (
      .clk    (clk),
      .reset  (reset),
      .en     (min_en),
      .ct_out (mins),
      .z      (min_z)
   );

   ct_mod_n #(.N(HR_MOD), .WIDTH(WIDTH)) u_hr (
      .clk    (clk),
      .reset  (reset),
      .en     (hr_en),
      .ct_out (hrs),
      .z      (hr_z)
   );

`ifdef TIME_DAY_COUNT_EN
   logic day_z_unused;

   ct_mod_n #(.N(DAY_MOD_D), .WIDTH(3)) u_day (
      .clk    (clk),
      .reset  (reset),
      .en     (wrap_d),
      .ct_out (days),
      .z      (day_z_unused)
   );
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         day_wrap_q <= 1'b0;
      end else begin
         day_wrap_q <= wrap_d;
      end
   end

   assign day_wrap = day_wrap_q;
endmodule

// File: tb/tb_time_counter_hms.sv
// Directed self-checking bench for time_counter_hms; covers the days counter
// when built with TIME_DAY_COUNT_EN.
module tb_time_counter_hms;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       run_en = 1'b1;
   logic       set_min = 1'b0;
   logic       set_hr = 1'b0;
   logic [7:0] secs, mins, hrs;
   logic       day_wrap;
`ifdef TIME_DAY_COUNT_EN
   logic [2:0] days;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   time_counter_hms dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .run_en   (run_en),
      .set_min  (set_min),
      .set_hr   (set_hr),
      .secs     (secs),
      .mins     (mins),
      .hrs      (hrs),
`ifdef TIME_DAY_COUNT_EN
      .days     (days),
`endif
      .day_wrap (day_wrap)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge, are sampled on the next rising edge,
   // and the outputs are observed on the following falling edge.
   task automatic step(input logic r, input logic tk, input logic sm, input logic sh);
      reset = r; tick = tk; set_min = sm; set_hr = sh;
      @(negedge clk);
      reset = 1'b0; tick = 1'b0; set_min = 1'b0; set_hr = 1'b0;
   endtask

   task automatic preload(input int h, input int m, input int s);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < h; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < m; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < s; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      preload(4, 5, 6);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      vec_cnt++;
      if ({hrs, mins, secs} !== 24'h000000) begin
         $display("FAIL reset_time got=%0d:%0d:%0d exp=0:0:0", hrs, mins, secs); err_cnt++;
      end
      vec_cnt++;
      if (day_wrap !== 1'b0) begin
         $display("FAIL reset_wrap got=%b exp=0", day_wrap); err_cnt++;
      end
   endtask

   task automatic test_sec_carry;
      for (int i = 0; i < 59; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      vec_cnt++;
      if ({hrs, mins, secs} !== {8'd0, 8'd0, 8'd59}) begin
         $display("FAIL sec59 got=%0d:%0d:%0d exp=0:0:59", hrs, mins, secs); err_cnt++;
      end
      step(1'b0, 1'b1, 1'b0, 1'b0);
      vec_cnt++;
      if ({hrs, mins, secs} !== {8'd0, 8'd1, 8'd0}) begin
         $display("FAIL sec_carry got=%0d:%0d:%0d exp=0:1:0", hrs, mins, secs); err_cnt++;
      end
   endtask

   task automatic test_day_rollover;
      preload(23, 59, 59);
      vec_cnt++;
      if ({hrs, mins, secs, day_wrap} !== {8'd23, 8'd59, 8'd59, 1'b0}) begin
         $display("FAIL preload_235959 got=%0d:%0d:%0d wrap=%b exp=23:59:59 wrap=0", hrs, mins, secs, day_wrap); err_cnt++;
      end
      step(1'b0, 1'b1, 1'b0, 1'b0);
      vec_cnt++;
      if ({hrs, mins, secs} !== 24'h000000) begin
         $display("FAIL rollover got=%0d:%0d:%0d exp=0:0:0", hrs, mins, secs); err_cnt++;
      end
      vec_cnt++;
      if (day_wrap !== 1'b1) begin
         $display("FAIL wrap_pulse got=%b exp=1", day_wrap); err_cnt++;
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      vec_cnt++;
      if ({hrs, mins, secs, day_wrap} !== {24'h000000, 1'b0}) begin
         $display("FAIL wrap_clear got=%0d:%0d:%0d wrap=%b exp=0:0:0 wrap=0", hrs, mins, secs, day_wrap); err_cnt++;
      end
   endtask

   task automatic test_freeze;
      preload(5, 10, 20);
      run_en = 1'b0;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      vec_cnt++;
      if ({hrs, mins, secs, day_wrap} !== {8'd5, 8'd10, 8'd20, 1'b0}) begin
         $display("FAIL freeze_run_en got=%0d:%0d:%0d wrap=%b exp=5:10:20 wrap=0", hrs, mins, secs, day_wrap); err_cnt++;
      end
      run_en = 1'b1;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      vec_cnt++;
      if ({hrs, mins, secs} !== {8'd5, 8'd10, 8'd20}) begin
         $display("FAIL freeze_no_tick got=%0d:%0d:%0d exp=5:10:20", hrs, mins, secs); err_cnt++;
      end
   endtask

   task automatic test_set_wrap;
      preload(3, 59, 15);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      vec_cnt++;
      if ({hrs, mins, secs} !== {8'd3, 8'd0, 8'd0}) begin
         $display("FAIL set_min_wrap got=%0d:%0d:%0d exp=3:0:0", hrs, mins, secs); err_cnt++;
      end
      preload(23, 59, 59);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      vec_cnt++;
      if ({hrs, mins, secs} !== {8'd0, 8'd59, 8'd0}) begin
         $display("FAIL set_hr_wrap got=%0d:%0d:%0d exp=0:59:0", hrs, mins, secs); err_cnt++;
      end
      vec_cnt++;
      if (day_wrap !== 1'b0) begin
         $display("FAIL set_hr_nowrap got=%b exp=0", day_wrap); err_cnt++;
      end
   endtask

   task automatic test_set_priority;
      preload(0, 7, 30);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      vec_cnt++;
      if ({hrs, mins, secs} !== {8'd0, 8'd8, 8'd0}) begin
         $display("FAIL tick_and_set got=%0d:%0d:%0d exp=0:8:0", hrs, mins, secs); err_cnt++;
      end
      preload(1, 2, 3);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      vec_cnt++;
      if ({hrs, mins, secs} !== {8'd2, 8'd3, 8'd0}) begin
         $display("FAIL set_both got=%0d:%0d:%0d exp=2:3:0", hrs, mins, secs); err_cnt++;
      end
      preload(0, 58, 10);
      set_min = 1'b1;
      repeat (3) @(negedge clk);
      set_min = 1'b0;
      vec_cnt++;
      if ({hrs, mins, secs} !== {8'd0, 8'd1, 8'd0}) begin
         $display("FAIL set_held got=%0d:%0d:%0d exp=0:1:0", hrs, mins, secs); err_cnt++;
      end
   endtask

   task automatic test_reset_priority;
      preload(0, 59, 59);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      vec_cnt++;
      if ({hrs, mins, secs, day_wrap} !== {24'h000000, 1'b0}) begin
         $display("FAIL reset_mid_carry got=%0d:%0d:%0d wrap=%b exp=0:0:0 wrap=0", hrs, mins, secs, day_wrap); err_cnt++;
      end
      preload(23, 59, 59);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      vec_cnt++;
      if ({hrs, mins, secs, day_wrap} !== {24'h000000, 1'b0}) begin
         $display("FAIL reset_mid_rollover got=%0d:%0d:%0d wrap=%b exp=0:0:0 wrap=0", hrs, mins, secs, day_wrap); err_cnt++;
      end
   endtask

`ifdef TIME_DAY_COUNT_EN
   task automatic test_days;
      logic [2:0] exp_day;
      preload(23, 59, 59);
      vec_cnt++;
      if (days !== 3'd0) begin
         $display("FAIL days_reset got=%0d exp=0", days); err_cnt++;
      end
      for (int d = 1; d <= 7; d++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         exp_day = 3'(d % 7);
         vec_cnt++;
         if (days !== exp_day) begin
            $display("FAIL days_seq got=%0d exp=%0d", days, exp_day); err_cnt++;
         end
         for (int i = 0; i < 23; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
         for (int i = 0; i < 59; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
         for (int i = 0; i < 59; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      end
   endtask
`endif

   initial begin
      @(negedge clk);
      @(negedge clk);
      test_reset();
      test_sec_carry();
      test_day_rollover();
      test_freeze();
      test_set_wrap();
      test_set_priority();
      test_reset_priority();
`ifdef TIME_DAY_COUNT_EN
      test_days();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/time_counter_hms.md
Name: time_counter_hms

Overview:
- Cascaded seconds/minutes/hours timekeeping counter for the lab clock datapath.
- Directly upstream of the 8-bit 2:1 display selector (mux2, WIDTH=8).
- Its registered minute and hour buses feed the selector's d0 input, which chooses between current time and the alarm setting.
- Advances on a one-cycle seconds tick; supports manual minute/hour setting via increment pulses.

Parameters:
- WIDTH, 8, width of each output field bus; must be ≥6; matches selector width.
- SEC_MOD, 60, seconds modulus.
- MIN_MOD, 60, minutes modulus.
- HR_MOD, 24, hours modulus.

Ports:
- clk      input   1      system clock; all state updates on rising edge.
- reset    input   1      synchronous, active-high reset.
- tick     input   1      one-cycle pulse, one per second.
- run_en   input   1      level; 1 = tick advances time, 0 = time frozen.
- set_min  input   1      one-cycle pulse; increment minutes, no carry.
- set_hr   input   1      one-cycle pulse; increment hours, no carry.
- secs     output  WIDTH  seconds, binary, 0..SEC_MOD-1.
- mins     output  WIDTH  minutes, binary, 0..MIN_MOD-1.
- hrs      output  WIDTH  hours, binary, 0..HR_MOD-1.
- day_wrap output  1      one-cycle pulse when the count wraps to 00:00:00.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: secs=0, mins=0, hrs=0, day_wrap=0 after the edge where reset=1. Reset overrides all other inputs on that edge, including reset mid-carry or mid-set.
- All outputs are registered. Latency is 1 cycle from input pulse to updated output.
- Run mode (set_min=0, set_hr=0, tick=1, run_en=1):
  - secs increments.
  - secs=SEC_MOD-1 → secs=0 and mins increments.
  - mins=MIN_MOD-1 with the seconds carry → mins=0 and hrs increments.
  - hrs=HR_MOD-1 with the minutes carry → hrs=0.
- Carry is combinational within the cycle. The full 23:59:59 → 00:00:00 rollover completes on a single edge.
- day_wrap=1 for exactly the cycle following that rollover edge; otherwise 0.
- tick with run_en=0: no change.
- tick=0: no change regardless of run_en.
- Set mode (set_min or set_hr asserted):
  - set_min: mins ← (mins+1) mod MIN_MOD. No carry into hrs.
  - set_hr: hrs ← (hrs+1) mod HR_MOD.
  - Both asserted: both fields increment on the same edge.
  - Any set pulse clears secs to 0 on that edge.
  - tick is ignored on that edge; set has priority over tick.
  - day_wrap never asserts due to set pulses.
- Field arithmetic is done in WIDTH bits and wraps modulo the field modulus. Upper bits of each output are always 0.
- Input pulses held longer than one cycle act once per cycle held; no edge detection is performed inside this block.

Optional Feature:
- Macro: TIME_DAY_COUNT_EN.
- Defined:
  - Adds output port `days` (3 bits), a mod-7 day-of-week counter.
  - Increments on each day_wrap event, wraps 6→0, resets to 0.
  - Set pulses do not affect it.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package time_pkg:
  - default modulus constants SEC_MOD_D=60, MIN_MOD_D=60, HR_MOD_D=24, DAY_MOD_D=7;
  - typedef field_t = logic [7:0].
- One sub-module, ct_mod_n:
  - parameter N, WIDTH;
  - ports clk, reset, en, ct_out, z;
  - ct_out increments mod N when en=1;
  - z = en && ct_out==N-1, combinational.
- time_counter_hms instantiates three ct_mod_n, plus a fourth under TIME_DAY_COUNT_EN.
- Set-mode enable and priority muxing stay in the top module.

Test Plan:
- Reset 2 cycles then release; apply 59 ticks with run_en=1 → secs=59, mins=0. 60th tick → secs=0, mins=1 one cycle later.
- Preload to 23:59:59 via set pulses plus ticks, then tick → next cycle 00:00:00, day_wrap=1 for exactly one cycle, then 0.
- run_en=0 with 10 ticks at 05:10:20 → outputs unchanged at 05:10:20, day_wrap=0.
- At mins=59, hrs=3, pulse set_min → mins=0, hrs=3, secs=0. At hrs=23 pulse set_hr → hrs=0, day_wrap stays 0.
- tick and set_min in the same cycle at 00:07:30 → 00:08:00. Then reset asserted in a cycle that also carries tick at 00:59:59 → 00:00:00, day_wrap=0.
- TIME_DAY_COUNT_EN defined: 7 full-day rollovers from 23:59:59 → days sequence 1,2,3,4,5,6,0. Macro undefined: build succeeds without `days`.
